uart_tx_sched: RTL
==================

# uart_tx_sched

Transmit scheduler in front of `uart_send`. It shares the single UART transmitter between two byte requesters (A and B) using round-robin arbitration with packet locking. For each accepted byte it drives `data` and a one-cycle `uart_done` strobe into `uart_send`. `uart_send` has no busy output, so this block times each frame itself and holds off the next byte until the frame has gone out.

## Interface
Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz
- UART_BPS, 115200, baud rate; BIT_CYC = CLK_FREQ/UART_BPS (integer division, 434 at defaults)
- GUARD_CYCLES, 16, idle cycles appended after each frame; FRAME_CYC = 10*BIT_CYC + GUARD_CYCLES (4356 at defaults)
- LOCK_TIMEOUT, 65535, idle-cycle limit while a packet lock is held

Ports:
- clk  input  1  system clock, the single clock domain
- rst_n  input  1  synchronous, active-high reset
- a_data  input  8  requester A byte
- a_valid  input  1  requester A has a byte
- a_last  input  1  A byte ends a packet
- a_ready  output  1  A byte accepted this cycle
- b_data, b_valid, b_last, b_ready  same widths and meanings for requester B
- tx_data  output  8  byte to `uart_send` `data`
- tx_start  output  1  one-cycle strobe to `uart_send` `uart_done`
- grant  output  2  one-hot owner of the last accepted byte (bit0 = A, bit1 = B); 00 when none
- busy  output  1  high in SEND and WAIT

## Operation
- Reset is synchronous and active-high: rst_n = 1 at a clk edge resets the block.
- Values after reset:
  - tx_data = 0x00, tx_start = 0, grant = 00, busy = 0, a_ready = b_ready = 0.
  - State = IDLE, lock cleared, round-robin priority pointer = A, counters = 0.
- A reset asserted in any state aborts immediately. No tx_start is issued after reset, and any pending byte is dropped.
- The state machine has three states: IDLE, SEND, WAIT.
- IDLE, eligibility:
  - If the lock is held, only the locked requester is eligible.
  - Otherwise both requesters are eligible.
- IDLE, selection:
  - If exactly one eligible requester has valid high, it is selected.
  - If both do, the one named by the priority pointer is selected.
- IDLE, handshake:
  - x_ready is combinational: (state == IDLE) && selected == x && x_valid.
  - The transfer completes at the clk edge where valid && ready.
  - On that edge: tx_data is loaded with x_data, grant is set to x, and the state goes to SEND.
- Lock update on each accepted byte:
  - x_last = 0: lock is held (or kept) on x.
  - x_last = 1: lock is cleared and the priority pointer moves to the other requester.
  - A single-byte packet (last = 1 on the first byte) never locks and advances the pointer.
- Lock timeout:
  - While locked in IDLE with the locked requester's valid low, an idle counter increments.
  - When the counter reaches LOCK_TIMEOUT, the lock is cleared, the pointer moves to the other requester, and the counter resets.
  - The counter resets on any accept and whenever the lock is not held.
- SEND: lasts exactly 1 cycle with tx_start = 1. The frame counter is loaded with FRAME_CYC-1, then the state goes to WAIT.
- WAIT:
  - The frame counter decrements each cycle.
  - When it is 0, the state goes to IDLE, so WAIT lasts exactly FRAME_CYC cycles.
  - Valid inputs are ignored in WAIT (ready = 0).
- tx_data holds its value from the SEND cycle until the next accept. grant holds until the next accept.
- The counter is wide enough for max(FRAME_CYC, LOCK_TIMEOUT). It must never wrap.

## Timing
- Byte accepted at edge E (IDLE cycle):
  - tx_start is high for the single cycle after E, and tx_data is already valid in that cycle.
  - WAIT occupies the next FRAME_CYC cycles.
  - The state is IDLE again FRAME_CYC+1 cycles after E.
- The earliest next accept is in that IDLE cycle. Minimum tx_start-to-tx_start spacing is FRAME_CYC+2 cycles (4358 at defaults).
- Sustained throughput is one byte per FRAME_CYC+2 cycles.
- ready is never high outside IDLE, and never high for both requesters in the same cycle.
- A requester may drop valid without a handshake. Nothing is latched unless valid && ready at the edge.
- Simultaneous events:
  - Both valid, unlocked: the priority pointer decides the winner.
  - Both valid, locked: the locked requester wins even if the pointer points to the other.
  - The lock timeout reached in the same cycle as the locked requester raising valid: the accept wins and the timeout is not applied.

## Test plan
- Reset, then a_valid = 1, a_data = 0x55, a_last = 1 -> a_ready high 1 cycle; tx_start pulse one cycle later with tx_data = 0x55; grant = 01; busy high for 4357 cycles.
- A and B both hold valid (a_data 0x11, b_data 0x22, last = 1) continuously from reset -> tx_data sequence 0x11, 0x22, 0x11, 0x22; tx_start spacing exactly 4358 cycles.
- A sends 3-byte packet 0xA0, 0xA1, 0xA2 (last on 0xA2) while B holds valid with 0xB0 -> output order 0xA0, 0xA1, 0xA2, 0xB0; b_ready never high before 0xA2 is accepted.
- A sends 0xC0 with last = 0, then drops valid; B valid; LOCK_TIMEOUT = 100 -> B is accepted in the IDLE cycle 100 cycles after IDLE is entered; a_ready stays 0 meanwhile.
- rst_n pulsed high during WAIT after 0x7E was sent -> all outputs return to reset values the next cycle; no further tx_start; next accept works normally.
- b_valid raised in WAIT with 0x33, last = 1 -> b_ready = 0 until the first IDLE cycle, then accepted; exactly one tx_start, with 0x33.

Source files
------------

// File: rtl/uart_tx_sched.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_tx_sched: round-robin, packet-locking scheduler feeding one uart_send
// Rev 1.0
// ----------------------------------------------------------------------------
module uart_tx_sched #(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int UART_BPS     = 115200,
  parameter int GUARD_CYCLES = 16,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] a_data,
  input  logic       a_valid,
  input  logic       a_last,
  output logic       a_ready,
  input  logic [7:0] b_data,
  input  logic       b_valid,
  input  logic       b_last,
  output logic       b_ready,
  output logic [7:0] tx_data,
  output logic       tx_start,
  output logic [1:0] grant,
  output logic       busy
);

  localparam int BIT_CYC   = CLK_FREQ / UART_BPS;
  localparam int FRAME_CYC = 10 * BIT_CYC + GUARD_CYCLES;
  localparam int CNT_MAX   = (FRAME_CYC > LOCK_TIMEOUT) ? FRAME_CYC : LOCK_TIMEOUT;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] FRAME_LOAD   = CNT_W'(FRAME_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic             r_lock;
  logic             r_lock_b;   // lock owner: 0 = A, 1 = B
  logic             r_ptr_b;    // round-robin priority: 0 = A, 1 = B
  logic [CNT_W-1:0] r_cnt;      // idle-lock counter in IDLE, frame counter in SEND/WAIT

  logic w_req_a, w_req_b, w_sel_a, w_sel_b;
  logic w_acc_a, w_acc_b, w_accept, w_acc_last, w_owner_valid;

  assign w_req_a       = a_valid && (!r_lock || !r_lock_b);
  assign w_req_b       = b_valid && (!r_lock ||  r_lock_b);
  assign w_sel_a       = w_req_a && (!w_req_b || !r_ptr_b);
  assign w_sel_b       = w_req_b && (!w_req_a ||  r_ptr_b);
  assign w_acc_a       = (r_state == S_IDLE) && w_sel_a;
  assign w_acc_b       = (r_state == S_IDLE) && w_sel_b;
  assign w_accept      = w_acc_a || w_acc_b;
  assign w_acc_last    = w_acc_a ? a_last : b_last;
  assign w_owner_valid = r_lock_b ? b_valid : a_valid;

  always_ff @(posedge clk) begin
    if (rst_n) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = S_IDLE;
    case (r_state)
      S_IDLE:  w_next_state = w_accept ? S_SEND : S_IDLE;
      S_SEND:  w_next_state = S_WAIT;
      S_WAIT:  w_next_state = (r_cnt == '0) ? S_IDLE : S_WAIT;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    a_ready  = w_acc_a;
    b_ready  = w_acc_b;
    tx_start = (r_state == S_SEND);
    busy     = (r_state == S_SEND) || (r_state == S_WAIT);
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      tx_data  <= 8'h00;
      grant    <= 2'b00;
      r_lock   <= 1'b0;
      r_lock_b <= 1'b0;
      r_ptr_b  <= 1'b0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      tx_data <= w_acc_a ? a_data : b_data;
      grant   <= {w_acc_b, w_acc_a};
      r_cnt   <= '0;
      if (w_acc_last) begin
        r_lock  <= 1'b0;
        r_ptr_b <= w_acc_a;
      end else begin
        r_lock   <= 1'b1;
        r_lock_b <= w_acc_b;
      end
    end else if (r_state == S_SEND) begin
      r_cnt <= FRAME_LOAD;
    end else if (r_state == S_WAIT) begin
      if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
    end else if (r_lock && !w_owner_valid) begin
      // Abandoned packet: release the lock once the idle limit is reached
      if (r_cnt == TIMEOUT_LAST) begin
        r_lock  <= 1'b0;
        r_ptr_b <= !r_lock_b;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end else begin
      r_cnt <= '0;
    end
  end

endmodule
`default_nettype wire
